// File: rtl/tiny_cpu_v2.sv
// tiny_cpu_v2: parametrised accumulator CPU on one shared instruction/data bus with a ready handshake.
// Define TINY_CPU_V2_MULDIV_EN to build MULT/DIV; otherwise opcodes 8 and 9 behave as NOP.
module tiny_cpu_v2 #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  read,
  output logic                  write,
  output logic [addr_width-1:0] addr,
  output logic [data_width-1:0] wdata,
  input  logic [data_width-1:0] rdata,
  input  logic                  ready,
  output logic                  halted,
  output logic [data_width-1:0] acc
);

  typedef enum logic [2:0] {S_FETCH, S_OPERAND, S_MEMRD, S_MEMWR, S_HALT} state_t;

  localparam logic [3:0] OP_MOVA  = 4'h1;
  localparam logic [3:0] OP_MOVB  = 4'h2;
  localparam logic [3:0] OP_MOVAM = 4'h3;
  localparam logic [3:0] OP_MOVBM = 4'h4;
  localparam logic [3:0] OP_MOVM  = 4'h5;
  localparam logic [3:0] OP_ADD   = 4'h6;
  localparam logic [3:0] OP_SUB   = 4'h7;
  localparam logic [3:0] OP_MULT  = 4'h8;
  localparam logic [3:0] OP_DIV   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JC    = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Bits of the operand word that can reach the address; the rest is zero-extended.
  localparam int CW = (addr_width < data_width) ? addr_width : data_width;

  state_t                r_state, w_state_next;
  logic [addr_width-1:0] r_pc, w_pc_next;
  logic [data_width-1:0] r_a, w_a_next;
  logic [data_width-1:0] r_b, w_b_next;
  logic                  r_z, w_z_next;
  logic                  r_c, w_c_next;
  logic [3:0]            r_op, w_op_next;
  logic                  r_read, w_read_next;
  logic                  r_write, w_write_next;
  logic [addr_width-1:0] r_addr, w_addr_next;
  logic [data_width-1:0] r_wdata, w_wdata_next;
  logic                  r_halted, w_halted_next;

  logic [3:0]            w_fetch_op;
  logic [addr_width-1:0] w_pc_inc;
  logic [addr_width-1:0] w_op_addr;
  logic                  w_needs_operand;
  logic [data_width:0]   w_sum;
  logic                  w_alu_hit;
  logic [data_width-1:0] w_alu_a;
  logic                  w_alu_c;

  assign w_fetch_op      = rdata[3:0];
  assign w_pc_inc        = r_pc + addr_width'(1);
  assign w_op_addr       = addr_width'(rdata[CW-1:0]);
  assign w_needs_operand = ((w_fetch_op >= OP_MOVA) && (w_fetch_op <= OP_MOVM)) ||
                           ((w_fetch_op >= OP_JMP)  && (w_fetch_op <= OP_JC));
  assign w_sum           = {1'b0, r_a} + {1'b0, r_b};

`ifdef TINY_CPU_V2_MULDIV_EN
  logic [2*data_width-1:0] w_prod;
  assign w_prod = {{data_width{1'b0}}, r_a} * {{data_width{1'b0}}, r_b};
`endif

  // ALU result for the opcode arriving on rdata; only used on a completing fetch.
  always_comb begin
    w_alu_hit = 1'b1;
    w_alu_a   = r_a;
    w_alu_c   = r_c;
    case (w_fetch_op)
      OP_ADD: {w_alu_c, w_alu_a} = w_sum;
      OP_SUB: begin
        w_alu_a = r_a - r_b;
        w_alu_c = (r_a < r_b);
      end
`ifdef TINY_CPU_V2_MULDIV_EN
      OP_MULT: begin
        w_alu_a = w_prod[data_width-1:0];
        w_alu_c = |w_prod[2*data_width-1:data_width];
      end
      OP_DIV: begin
        if (r_b == '0) begin
          w_alu_a = '1;
          w_alu_c = 1'b1;
        end else begin
          w_alu_a = r_a / r_b;
          w_alu_c = 1'b0;
        end
      end
`endif
      default: w_alu_hit = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every target is defaulted to its current value first, so no path infers a latch.
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_z_next      = r_z;
    w_c_next      = r_c;
    w_op_next     = r_op;
    w_read_next   = r_read;
    w_write_next  = r_write;
    w_addr_next   = r_addr;
    w_wdata_next  = r_wdata;
    w_halted_next = r_halted;
    case (r_state)
      S_FETCH: begin
        if (!r_read) begin
          // First cycle out of reset: raise the fetch request.
          w_read_next = 1'b1;
          w_addr_next = r_pc;
        end else if (ready) begin
          w_pc_next = w_pc_inc;
          w_op_next = w_fetch_op;
          if (w_fetch_op == OP_HALT) begin
            w_state_next  = S_HALT;
            w_read_next   = 1'b0;
            w_halted_next = 1'b1;
          end else begin
            w_addr_next = w_pc_inc;
            if (w_needs_operand) begin
              w_state_next = S_OPERAND;
            end else if (w_alu_hit) begin
              w_a_next = w_alu_a;
              w_c_next = w_alu_c;
              w_z_next = (w_alu_a == '0);
            end
          end
        end
      end
      S_OPERAND: begin
        if (ready) begin
          w_state_next = S_FETCH;
          w_pc_next    = w_pc_inc;
          w_addr_next  = w_pc_inc;
          case (r_op)
            OP_MOVA: w_a_next = rdata;
            OP_MOVB: w_b_next = rdata;
            OP_MOVAM, OP_MOVBM: begin
              w_state_next = S_MEMRD;
              w_addr_next  = w_op_addr;
            end
            OP_MOVM: begin
              w_state_next = S_MEMWR;
              w_read_next  = 1'b0;
              w_write_next = 1'b1;
              w_addr_next  = w_op_addr;
              w_wdata_next = r_a;
            end
            OP_JMP: begin
              w_pc_next   = w_op_addr;
              w_addr_next = w_op_addr;
            end
            OP_JZ: begin
              if (r_z) begin
                w_pc_next   = w_op_addr;
                w_addr_next = w_op_addr;
              end
            end
            OP_JC: begin
              if (r_c) begin
                w_pc_next   = w_op_addr;
                w_addr_next = w_op_addr;
              end
            end
            default: ;
          endcase
        end
      end
      S_MEMRD: begin
        if (ready) begin
          w_state_next = S_FETCH;
          w_addr_next  = r_pc;
          if (r_op == OP_MOVAM) w_a_next = rdata;
          else                  w_b_next = rdata;
        end
      end
      S_MEMWR: begin
        if (ready) begin
          w_state_next = S_FETCH;
          w_write_next = 1'b0;
          w_wdata_next = '0;
          w_read_next  = 1'b1;
          w_addr_next  = r_pc;
        end
      end
      S_HALT:  ;
      default: w_state_next = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_op     <= '0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_z      <= w_z_next;
      r_c      <= w_c_next;
      r_op     <= w_op_next;
      r_read   <= w_read_next;
      r_write  <= w_write_next;
      r_addr   <= w_addr_next;
      r_wdata  <= w_wdata_next;
      r_halted <= w_halted_next;
    end
  end

  assign read   = r_read;
  assign write  = r_write;
  assign addr   = r_addr;
  assign wdata  = r_wdata;
  assign halted = r_halted;
  assign acc    = r_a;

endmodule
